// File: rtl/toggle_burst_arb_if.sv
// Request/grant bundle for the two-requester toggle burst arbiter.
// The master side raises requests and burst parameters; the slave side returns grant, status and toggle.
interface toggle_burst_arb_if #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
);
   logic [1:0]       req;
   logic [CNT_W-1:0] period0;
   logic [CNT_W-1:0] period1;
   logic [NUM_W-1:0] count0;
   logic [NUM_W-1:0] count1;
   logic [1:0]       gnt;
   logic             busy;
   logic [1:0]       done;
   logic             toggle;

   modport master (
      output req, period0, period1, count0, count1,
      input  gnt, busy, done, toggle
   );

   modport slave (
      input  req, period0, period1, count0, count1,
      output gnt, busy, done, toggle
   );
endinterface

// File: rtl/toggle_burst_arb.sv
// Round-robin arbiter granting one requester a burst of toggle flips at its own half-period.
// Grant is registered one edge after a request; req is a level, dropping it mid-burst aborts the burst.
module toggle_burst_arb #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   toggle_burst_arb_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             toggle_q, toggle_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [NUM_W-1:0] rem_q, rem_d;

   logic win;
   logic hit;
   logic abort;

   // On a tie the requester not served last wins.
   assign win   = (bus.req == 2'b11) ? ~last_q : bus.req[1];
   assign hit   = (cnt_q == per_q);
   assign abort = ((bus.req & gnt_q) == 2'b00);

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = 2'b00;
      toggle_d = toggle_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      per_d    = per_q;
      rem_d    = rem_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req != 2'b00) begin
               gnt_d   = win ? 2'b10 : 2'b01;
               per_d   = win ? bus.period1 : bus.period0;
               rem_d   = win ? bus.count1 : bus.count0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (rem_q == '0) begin
               state_d = S_DONE;
               done_d  = gnt_q;
               last_d  = gnt_q[1];
            end else if (hit && (rem_q == NUM_W'(1))) begin
               // Final flip wins over a simultaneous abort.
               toggle_d = ~toggle_q;
               cnt_d    = '0;
               rem_d    = '0;
               state_d  = S_DONE;
               done_d   = gnt_q;
               last_d   = gnt_q[1];
            end else if (abort) begin
               state_d = S_IDLE;
               gnt_d   = 2'b00;
               cnt_d   = '0;
            end else if (hit) begin
               toggle_d = ~toggle_q;
               cnt_d    = '0;
               rem_d    = rem_q - NUM_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         toggle_q <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         per_q    <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         toggle_q <= toggle_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         rem_q    <= rem_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.done   = done_q;
   assign bus.toggle = toggle_q;
   assign bus.busy   = (state_q != S_IDLE);
endmodule
